// File: rtl/booth_mult_ctrl.sv
// Sequencing controller for the radix-2 Booth multiplier datapath: handshake, clear/load,
// one EVAL/SHIFT pair per multiplier bit, then product capture with a one-cycle done pulse.
module booth_mult_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A_in,
    input  logic [N-1:0]     B_in,
    output logic             ready,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [N-1:0]     dp_A,
    output logic [N-1:0]     dp_B,
    output logic             dp_rst,
    output logic             load_A,
    output logic             load_B,
    output logic             load_add,
    output logic             shift_HQ_LQ_Q_1,
    output logic             add_sub,
    input  logic [1:0]       Q_LSB,
    input  logic [2*N-1:0]   Y
);

    localparam int unsigned CntW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StEval,
        StShift,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]        dp_a_q, dp_a_d;
    logic [N-1:0]        dp_b_q, dp_b_d;
    logic [2*N-1:0]      product_q, product_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                load_ab_q, load_ab_d;
    logic                shift_q, shift_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dp_a_d    = dp_a_q;
        dp_b_d    = dp_b_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dp_a_d  = A_in;
                    dp_b_d  = B_in;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: state_d = StLoad;
            StLoad:  state_d = StEval;
            StEval:  state_d = StShift;
            StShift: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CntW'(N - 1)) ? StDone : StEval;
            end
            StDone: begin
                product_d = Y;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered Moore outputs are computed from the state being entered.
        ready_d   = (state_d == StIdle);
        done_d    = (state_d == StDone);
        load_ab_d = (state_d == StLoad);
        shift_d   = (state_d == StShift);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            load_ab_q <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_a_q    <= dp_a_d;
            dp_b_q    <= dp_b_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            load_ab_q <= load_ab_d;
            shift_q   <= shift_d;
        end
    end

    // Q_LSB is only valid after the datapath registers settle, so the add/sub
    // decode must look at the current pair rather than a registered copy.
    always_comb begin
        load_add = 1'b0;
        add_sub  = 1'b0;
        if (state_q == StEval) begin
            load_add = (Q_LSB == 2'b01) || (Q_LSB == 2'b10);
            add_sub  = (Q_LSB == 2'b01);
        end
    end

    assign dp_rst          = !rst || (state_q == StClear);
    assign ready           = ready_q;
    assign done            = done_q;
    assign product         = product_q;
    assign dp_A            = dp_a_q;
    assign dp_B            = dp_b_q;
    assign load_A          = load_ab_q;
    assign load_B          = load_ab_q;
    assign shift_HQ_LQ_Q_1 = shift_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Bench for booth_mult_ctrl: a Booth datapath model closes the loop, a schedule model
// predicts every output each cycle, and directed vectors pin literal expectations.
module tb_booth_mult_ctrl;

    localparam int unsigned N = 8;
    localparam int LastPh = 2 * N + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N-1:0]     A_in, B_in;
    logic             ready, done;
    logic [2*N-1:0]   product;
    logic [N-1:0]     dp_A, dp_B;
    logic             dp_rst, load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub;
    logic [1:0]       Q_LSB;
    logic [2*N-1:0]   Y;

    booth_mult_ctrl #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .A_in            (A_in),
        .B_in            (B_in),
        .ready           (ready),
        .done            (done),
        .product         (product),
        .dp_A            (dp_A),
        .dp_B            (dp_B),
        .dp_rst          (dp_rst),
        .load_A          (load_A),
        .load_B          (load_B),
        .load_add        (load_add),
        .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
        .add_sub         (add_sub),
        .Q_LSB           (Q_LSB),
        .Y               (Y)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tick = 0;
    int base = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) tick <= tick + 1;

    // Booth datapath: M, {HQ, LQ, Q_1}, driven only by the controller's strobes.
    logic [N-1:0] hq, lq, m;
    logic         q1;
    logic         ovr_en = 1'b0;
    logic [2*N-1:0] ovr_val = '0;

    always @(posedge clk) begin
        if (dp_rst) begin
            hq <= '0; lq <= '0; q1 <= 1'b0; m <= '0;
        end else begin
            if (load_A) m <= dp_A;
            if (load_B) lq <= dp_B;
            if (load_add) hq <= add_sub ? hq + m : hq - m;
            if (shift_HQ_LQ_Q_1) {hq, lq, q1} <= {hq[N-1], hq, lq};
        end
    end

    assign Q_LSB = {lq[0], q1};
    assign Y     = ovr_en ? ovr_val : {hq, lq};

    // Schedule model: phase counts cycles since acceptance.
    bit             m_busy = 1'b0;
    int             m_phase = 0;
    logic [N-1:0]   m_a = '0, m_b = '0;
    logic [2*N-1:0] m_prod = '0;

    function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] sa, sb;
        sa = {{N{a[N-1]}}, a};
        sb = {{N{b[N-1]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; m_prod = '0; m_a = '0; m_b = '0;
        end else if (m_busy) begin
            if (m_phase == LastPh) begin
                m_prod = ovr_en ? ovr_val : smul(m_a, m_b);
                m_busy = 1'b0;
            end else begin
                m_phase++;
            end
        end else if (start) begin
            m_busy = 1'b1; m_phase = 1; m_a = A_in; m_b = B_in;
        end
    end

    int       c_i;
    bit       c_eval, c_shift;
    logic [1:0] c_pair;

    always @(negedge clk) begin
        if (chk_en) begin
            c_eval  = m_busy && m_phase >= 3 && m_phase <= 2 * N + 1 && (m_phase % 2 == 1);
            c_shift = m_busy && m_phase >= 4 && m_phase <= 2 * N + 2 && (m_phase % 2 == 0);
            c_i     = c_eval ? (m_phase - 3) / 2 : 0;
            c_pair  = {m_b[c_i], (c_i == 0) ? 1'b0 : m_b[c_i - 1]};
            chk("cmp_ready", ready, !m_busy);
            chk("cmp_done", done, m_busy && m_phase == LastPh);
            chk("cmp_dp_rst", dp_rst, !rst || (m_busy && m_phase == 1));
            chk("cmp_load_A", load_A, m_busy && m_phase == 2);
            chk("cmp_load_B", load_B, m_busy && m_phase == 2);
            chk("cmp_load_add", load_add, c_eval && (c_pair == 2'b01 || c_pair == 2'b10));
            chk("cmp_add_sub", add_sub, c_eval && c_pair == 2'b01);
            chk("cmp_shift", shift_HQ_LQ_Q_1, c_shift);
            chk("cmp_product", product, m_prod);
            chk("cmp_dp_A", dp_A, m_a);
            chk("cmp_dp_B", dp_B, m_b);
            if (done === 1'b1) n_done++;
        end
    end

    task automatic tick_to(input int k);
        while (tick - base < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp);
        base = tick; A_in = a; B_in = b; start = 1'b1;
        tick_to(1);
        start = 1'b0; A_in = ~a; B_in = ~b;
        tick_to(18); #2 chk("op_done_early", done, 1'b0);
        tick_to(19); #2 chk("op_done_19", done, 1'b1);
        tick_to(20); #2 chk("op_product", product, exp);
        tick_to(22);
    endtask

    logic [1:0] exp_q  [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_as [8] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    int d0;

    initial begin
        rst = 1'b0; start = 1'b1; A_in = 8'h11; B_in = 8'h22;
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        #2;
        chk("rst_dp_rst", dp_rst, 1'b1);
        chk("rst_product", product, 16'h0000);
        chk("rst_ready", ready, 1'b1);
        chk("rst_strobes", {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}, 5'b0);
        @(posedge clk); #1 rst = 1'b1; start = 1'b0;
        @(posedge clk); #3;
        chk("rst_no_accept_ready", ready, 1'b1);
        chk("rst_no_accept_dpA", dp_A, 8'h00);

        // A=3, B=5 strobe trace with a busy start at cycle 5 and Y forced at cycle 19.
        @(posedge clk); #1;
        d0 = n_done;
        base = tick; A_in = 8'h03; B_in = 8'h05; start = 1'b1;
        tick_to(1); start = 1'b0;
        tick_to(1); #2 chk("tr_clear", dp_rst, 1'b1);
        tick_to(2); #2 chk("tr_load", {load_A, load_B}, 2'b11);
        for (int i = 0; i < 8; i++) begin
            tick_to(3 + 2 * i);
            if (i == 1) begin start = 1'b1; A_in = 8'h7F; end
            #2;
            chk("tr_qlsb", Q_LSB, exp_q[i]);
            chk("tr_add_sub", {load_add, add_sub}, exp_as[i]);
            if (i == 4) chk("busy_dpA", dp_A, 8'h03);
            tick_to(4 + 2 * i);
            if (i == 1) start = 1'b0;
            #2 chk("tr_shift", shift_HQ_LQ_Q_1, 1'b1);
        end
        chk("tr_done_18", done, 1'b0);
        tick_to(19); ovr_val = 16'hBEEF; ovr_en = 1'b1;
        #2 chk("cap_done_19", done, 1'b1);
        tick_to(20); ovr_en = 1'b0;
        #2 chk("cap_done_20", done, 1'b0);
        chk("cap_product", product, 16'hBEEF);
        tick_to(30); #2;
        chk("busy_single_done", n_done - d0, 1);
        chk("busy_no_restart", ready, 1'b1);
        chk("cap_product_held", product, 16'hBEEF);

        run_op(8'hF9, 8'h0D, 16'hFFA5);
        run_op(8'h55, 8'hAA, 16'hE372);
        run_op(8'h7F, 8'h7F, 16'h3F01);
        run_op(8'h05, 8'h80, 16'hFD80);

        // Abort mid-operation.
        d0 = n_done;
        base = tick; A_in = 8'h09; B_in = 8'h06; start = 1'b1;
        tick_to(1); start = 1'b0;
        tick_to(10); rst = 1'b0;
        #2 chk("mid_dp_rst", dp_rst, 1'b1);
        tick_to(11); #2;
        chk("mid_ready", ready, 1'b1);
        chk("mid_product", product, 16'h0000);
        tick_to(12); rst = 1'b1;
        tick_to(40); #2 chk("mid_no_done", n_done - d0, 0);
        run_op(8'h09, 8'h06, 16'h0036);

        // Back-to-back with start held.
        base = tick; A_in = 8'h02; B_in = 8'h03; start = 1'b1;
        tick_to(2); A_in = 8'h04; B_in = 8'h05;
        tick_to(19); #2 chk("b2b_done1", done, 1'b1);
        tick_to(20); #2 chk("b2b_ready20", ready, 1'b1);
        chk("b2b_prod1", product, 16'h0006);
        tick_to(21); start = 1'b0;
        #2 chk("b2b_busy21", ready, 1'b0);
        tick_to(38); #2 chk("b2b_done38", done, 1'b0);
        tick_to(39); #2 chk("b2b_done2", done, 1'b1);
        tick_to(40); #2 chk("b2b_prod2", product, 16'h0014);
        tick_to(44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
